operand_fetch: RTL

//  Register-file read stage: drives regfile read addresses, captures the data returned
//  one cycle later, bypasses same-cycle and later writeback data, and presents a 2-entry

---
 rtl/operand_fetch.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Register-file read stage with writeback bypass and a 2-entry (OUT + SKID) operand buffer.
// Optional back-pressure counter enabled by defining OPFETCH_STALL_CNT_EN.
`ifndef RV_BIT_NUM
`define RV_BIT_NUM 32
`endif
`ifndef ADDR_BIT_NUM
`define ADDR_BIT_NUM 5
`endif

module operand_fetch #(
    parameter int unsigned XLEN = `RV_BIT_NUM,
    parameter int unsigned AW   = `ADDR_BIT_NUM,
    parameter int unsigned PW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [AW-1:0]   in_rs2_addr,
    input  logic [PW-1:0]   in_payload,
    output logic [AW-1:0]   rf_rs1_addr,
    output logic [AW-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [PW-1:0]   out_payload,
    output logic [31:0]     stall_cnt
);

    // Replace an operand with writeback data when a nonzero register is being written.
    function automatic logic [XLEN-1:0] snoop(input logic [AW-1:0]   a,
                                              input logic [XLEN-1:0] d,
                                              input logic            we,
                                              input logic [AW-1:0]   wa,
                                              input logic [XLEN-1:0] wd);
        return (we && (wa == a) && (a != '0)) ? wd : d;
    endfunction

    logic            s1_valid_q, s1_valid_d;
    logic [AW-1:0]   s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
    logic [PW-1:0]   s1_pl_q, s1_pl_d;
    logic            s1_byp1_q, s1_byp1_d, s1_byp2_q, s1_byp2_d;
    logic [XLEN-1:0] s1_bd1_q, s1_bd1_d, s1_bd2_q, s1_bd2_d;

    logic            skid_valid_q, skid_valid_d;
    logic [AW-1:0]   skid_rs1_q, skid_rs1_d, skid_rs2_q, skid_rs2_d;
    logic [XLEN-1:0] skid_op1_q, skid_op1_d, skid_op2_q, skid_op2_d;
    logic [PW-1:0]   skid_pl_q, skid_pl_d;

    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [XLEN-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [PW-1:0]   out_pl_q, out_pl_d;

    logic            accept;
    logic            out_free;
    logic [XLEN-1:0] res_op1, res_op2;

    assign in_ready    = rst_n && !skid_valid_q && !(s1_valid_q && out_valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign out_free    = !out_valid_q || out_ready;
    assign rf_rs1_addr = accept ? in_rs1_addr : '0;
    assign rf_rs2_addr = accept ? in_rs2_addr : '0;

    // Newest write wins: current writeback, then accept-time bypass, then regfile data.
    assign res_op1 = (s1_rs1_q == '0) ? '0 :
                     snoop(s1_rs1_q, s1_byp1_q ? s1_bd1_q : rf_rs1_data, wb_wen, wb_waddr, wb_wdata);
    assign res_op2 = (s1_rs2_q == '0) ? '0 :
                     snoop(s1_rs2_q, s1_byp2_q ? s1_bd2_q : rf_rs2_data, wb_wen, wb_waddr, wb_wdata);

    always_comb begin
        s1_valid_d   = accept;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_pl_d      = s1_pl_q;
        s1_byp1_d    = s1_byp1_q;
        s1_byp2_d    = s1_byp2_q;
        s1_bd1_d     = s1_bd1_q;
        s1_bd2_d     = s1_bd2_q;
        skid_valid_d = skid_valid_q;
        skid_rs1_d   = skid_rs1_q;
        skid_rs2_d   = skid_rs2_q;
        skid_op1_d   = snoop(skid_rs1_q, skid_op1_q, wb_wen, wb_waddr, wb_wdata);
        skid_op2_d   = snoop(skid_rs2_q, skid_op2_q, wb_wen, wb_waddr, wb_wdata);
        skid_pl_d    = skid_pl_q;
        out_valid_d  = out_valid_q;
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_op1_d    = snoop(out_rs1_q, out_op1_q, wb_wen, wb_waddr, wb_wdata);
        out_op2_d    = snoop(out_rs2_q, out_op2_q, wb_wen, wb_waddr, wb_wdata);
        out_pl_d     = out_pl_q;

        if (accept) begin
            s1_rs1_d  = in_rs1_addr;
            s1_rs2_d  = in_rs2_addr;
            s1_pl_d   = in_payload;
            s1_byp1_d = wb_wen && (wb_waddr == in_rs1_addr) && (in_rs1_addr != '0);
            s1_byp2_d = wb_wen && (wb_waddr == in_rs2_addr) && (in_rs2_addr != '0);
            s1_bd1_d  = wb_wdata;
            s1_bd2_d  = wb_wdata;
        end

        // SKID drains first; S1 is necessarily empty while SKID holds an entry.
        if (skid_valid_q) begin
            if (out_free) begin
                out_valid_d  = 1'b1;
                out_rs1_d    = skid_rs1_q;
                out_rs2_d    = skid_rs2_q;
                out_op1_d    = skid_op1_d;
                out_op2_d    = skid_op2_d;
                out_pl_d     = skid_pl_q;
                skid_valid_d = 1'b0;
            end
        end else if (s1_valid_q) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_rs1_d   = s1_rs1_q;
                out_rs2_d   = s1_rs2_q;
                out_op1_d   = res_op1;
                out_op2_d   = res_op2;
                out_pl_d    = s1_pl_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_rs1_d   = s1_rs1_q;
                skid_rs2_d   = s1_rs2_q;
                skid_op1_d   = res_op1;
                skid_op2_d   = res_op2;
                skid_pl_d    = s1_pl_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= '0;
            s1_rs2_q     <= '0;
            s1_pl_q      <= '0;
            s1_byp1_q    <= 1'b0;
            s1_byp2_q    <= 1'b0;
            s1_bd1_q     <= '0;
            s1_bd2_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_rs1_q   <= '0;
            skid_rs2_q   <= '0;
            skid_op1_q   <= '0;
            skid_op2_q   <= '0;
            skid_pl_q    <= '0;
            out_valid_q  <= 1'b0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_pl_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_pl_q      <= s1_pl_d;
            s1_byp1_q    <= s1_byp1_d;
            s1_byp2_q    <= s1_byp2_d;
            s1_bd1_q     <= s1_bd1_d;
            s1_bd2_q     <= s1_bd2_d;
            skid_valid_q <= skid_valid_d;
            skid_rs1_q   <= skid_rs1_d;
            skid_rs2_q   <= skid_rs2_d;
            skid_op1_q   <= skid_op1_d;
            skid_op2_q   <= skid_op2_d;
            skid_pl_q    <= skid_pl_d;
            out_valid_q  <= out_valid_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_pl_q     <= out_pl_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_op1_q;
    assign out_rs2_data = out_op2_q;
    assign out_payload  = out_pl_q;

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where execute holds off a valid operand pair.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
